// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit, initiator toward data memory
//
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses trap
// instead of issuing a request; default build ignores misalignment).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   MemWriteM, MemReadM        store / load in MEM stage (both high = load)
//   funct3M                    access size and signedness
//   ALUResultM, WriteDataM     byte address, unshifted store data
//   StallM                     holds the upstream pipeline registers
//   ReadDataM                  extended load result, valid in DONE
//   mem_valid/mem_ready        request channel (we, addr, wdata, wstrb)
//   mem_rvalid/mem_rdata       read response channel
//   MisalignM                  misaligned-access pulse (trap build only)

module mem_stage_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT_W  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [2:0]            funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic                  StallM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  MisalignM
);

    if (DATA_WIDTH != 32 || TIMEOUT_W != 0) begin : g_cfg_check
        $error("mem_stage_lsu: only DATA_WIDTH=32 and TIMEOUT_W=0 are supported");
    end

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_stall;

    logic                    r_valid;
    logic                    r_we;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [3:0]              r_wstrb;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_off;
    logic [2:0]              r_funct3;
    logic                    r_is_load;

    logic                    w_req;
    logic [1:0]              w_a;
    logic [1:0]              w_off;
    logic [3:0]              w_strb;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [DATA_WIDTH-1:0]   w_load_ext;
    logic                    w_misalign;

    assign w_req = MemWriteM | MemReadM;
    assign w_a   = ALUResultM[1:0];

    // Effective lane offset: halves only honour a[1], words always start at lane 0,
    // so a misaligned access in the non-trap build degrades to the aligned one.
    always_comb begin
        w_off  = 2'b00;
        w_strb = 4'b1111;
        case (funct3M[1:0])
            2'b00: begin
                w_off  = w_a;
                w_strb = 4'b0001 << w_a;
            end
            2'b01: begin
                w_off  = {w_a[1], 1'b0};
                w_strb = 4'b0011 << {w_a[1], 1'b0};
            end
            default: begin
                w_off  = 2'b00;
                w_strb = 4'b1111;
            end
        endcase
    end

    assign w_wdata = WriteDataM << {w_off, 3'b000};

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((funct3M[1:0] == 2'b01) && w_a[0]) ||
                        (funct3M[1] && (w_a != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Load extraction uses the offset/funct3 captured in IDLE, not the live inputs.
    assign w_shifted = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_ext = w_shifted;
        case (r_funct3)
            3'b000:  w_load_ext = {{(DATA_WIDTH-8){w_shifted[7]}},   w_shifted[7:0]};
            3'b001:  w_load_ext = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_ext = {{(DATA_WIDTH-8){1'b0}},           w_shifted[7:0]};
            3'b101:  w_load_ext = {{(DATA_WIDTH-16){1'b0}},          w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Stall drops only in DONE so the pipeline advances exactly once per access.
    always_comb begin
        w_next  = r_state;
        w_stall = w_req & (r_state != S_DONE);
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = w_misalign ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    w_next = r_is_load ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= 4'b0000;
            r_rdata   <= '0;
            r_off     <= 2'b00;
            r_funct3  <= 3'b000;
            r_is_load <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_misalign) begin
                            r_rdata <= '0;
                        end else begin
                            r_valid   <= 1'b1;
                            r_we      <= MemWriteM & ~MemReadM;
                            r_addr    <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                            r_wdata   <= w_wdata;
                            r_wstrb   <= MemReadM ? 4'b0000 : w_strb;
                            r_off     <= w_off;
                            r_funct3  <= funct3M;
                            r_is_load <= MemReadM;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_rdata <= w_load_ext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= (r_state == S_IDLE) & w_req & w_misalign;
        end
    end

    assign MisalignM = r_misalign;
`else
    assign MisalignM = 1'b0;
`endif

    assign StallM    = w_stall;
    assign ReadDataM = r_rdata;
    assign mem_valid = r_valid;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard testbench for mem_stage_lsu

module tb_mem_stage_lsu;

    logic        clk;
    logic        rst_n;
    logic        MemWriteM;
    logic        MemReadM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        MisalignM;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          stalls;
        bit          is_load;
    } exp_t;

    exp_t exp_q[$];

    mem_stage_lsu #(.DATA_WIDTH(32), .TIMEOUT_W(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .MisalignM  (MisalignM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'd0) begin
            case (a)
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end else if (sz == 2'd1) begin
            return a[1] ? 4'b1100 : 4'b0011;
        end
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return {4{wd[7:0]}};
        if (sz == 2'd1) return {2{wd[15:0]}};
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return b[7]  ? {24'hFFFFFF, b} : {24'h0, b};
            3'b001:  return h[15] ? {16'hFFFF, h}   : {16'h0, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic run_access(input string tag, input logic we, input logic re,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rword,
                              input int rdy_dly, input int rv_dly,
                              input logic [31:0] e_addr, input logic e_we,
                              input logic [3:0] e_strb, input logic [31:0] e_wdata,
                              input logic [31:0] e_rd);
        exp_t        e;
        logic [31:0] g_addr, g_wdata;
        logic        g_we;
        logic [3:0]  g_strb;
        int          stalls, k, w;
        bit          accepted, stable, done, first;

        e.addr    = e_addr;
        e.we      = e_we;
        e.wstrb   = e_strb;
        e.wdata   = e_wdata;
        e.rd      = e_rd;
        e.is_load = re;
        e.stalls  = re ? (rdy_dly + rv_dly + 3) : (rdy_dly + 2);
        exp_q.push_back(e);

        @(posedge clk); #1;
        MemWriteM  = we;
        MemReadM   = re;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        stalls = 0; k = 0; w = 0;
        accepted = 0; stable = 1; done = 0; first = 1;
        g_addr = '0; g_wdata = '0; g_we = 0; g_strb = '0;

        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            // Inputs other than the request flags are don't-care once captured.
            if (!first) begin
                funct3M    = 3'($urandom);
                ALUResultM = $urandom;
                WriteDataM = $urandom;
            end
            first      = 0;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (StallM) stalls++;
            if (!StallM) begin
                done = 1;
            end else if (mem_valid) begin
                if (k == 0) begin
                    g_addr = mem_addr; g_we = mem_we; g_strb = mem_wstrb; g_wdata = mem_wdata;
                end else if (mem_addr !== g_addr || mem_we !== g_we ||
                             mem_wstrb !== g_strb || mem_wdata !== g_wdata) begin
                    stable = 0;
                end
                if (k >= rdy_dly) begin
                    mem_ready = 1'b1;
                    accepted  = 1;
                end else begin
                    // stray response while the request is pending must be ignored
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                end
                k++;
            end else if (accepted && re) begin
                if (w == rv_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rword;
                end
                w++;
            end
        end

        e = exp_q.pop_front();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_addr"}, g_addr, e.addr);
        check({tag, "_we"}, 32'(g_we), 32'(e.we));
        check({tag, "_wstrb"}, 32'(g_strb), 32'(e.wstrb));
        if (!e.is_load)
            check({tag, "_wdata"}, g_wdata & mask_of(e.wstrb), e.wdata & mask_of(e.wstrb));
        check({tag, "_stable"}, 32'(stable), 32'd1);
        check({tag, "_stalls"}, 32'(stalls), 32'(e.stalls));
        if (e.is_load)
            check({tag, "_rdata"}, ReadDataM, e.rd);

        @(posedge clk); #1;
        MemWriteM  = 1'b0;
        MemReadM   = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [1:0]  sz, a;
        logic [31:0] addr, wd, rw;
        bit          ld, seen;

        rst_n = 1'b0; MemWriteM = 0; MemReadM = 0; funct3M = 0;
        ALUResultM = 0; WriteDataM = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(mem_valid), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_wstrb", 32'(mem_wstrb), 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", ReadDataM, 0);
        check("rst_misalign", 32'(MisalignM), 0);
        rst_n = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check("idle_stall", 32'(StallM), 0);
            check("idle_valid", 32'(mem_valid), 0);
        end

        run_access("sw",  1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0,
                   32'h100, 1, 4'b1111, 32'hDEADBEEF, 0);
        run_access("sb",  1, 0, 3'b000, 32'h203, 32'h000000AB, 0, 1, 0,
                   32'h200, 1, 4'b1000, 32'hAB000000, 0);
        run_access("sh",  1, 0, 3'b001, 32'h102, 32'h00001234, 0, 2, 0,
                   32'h100, 1, 4'b1100, 32'h12340000, 0);
        run_access("lb",  0, 1, 3'b000, 32'h101, 0, 32'h00008000, 0, 3,
                   32'h100, 0, 4'b0000, 0, 32'hFFFFFF80);
        run_access("lbu", 0, 1, 3'b100, 32'h101, 0, 32'h00008000, 0, 3,
                   32'h100, 0, 4'b0000, 0, 32'h00000080);
        run_access("lh",  0, 1, 3'b001, 32'h102, 0, 32'h7FFF1234, 4, 0,
                   32'h100, 0, 4'b0000, 0, 32'h00007FFF);
        run_access("lh_neg", 0, 1, 3'b001, 32'h300, 0, 32'h12348001, 0, 1,
                   32'h300, 0, 4'b0000, 0, 32'hFFFF8001);
        run_access("lhu", 0, 1, 3'b101, 32'h300, 0, 32'h12348001, 1, 0,
                   32'h300, 0, 4'b0000, 0, 32'h00008001);
        run_access("lw",  0, 1, 3'b010, 32'h104, 0, 32'hCAFEF00D, 1, 0,
                   32'h104, 0, 4'b0000, 0, 32'hCAFEF00D);
        run_access("both_is_load", 1, 1, 3'b010, 32'h40C, 32'h55555555, 32'h0BADC0DE, 0, 0,
                   32'h40C, 0, 4'b0000, 0, 32'h0BADC0DE);

        for (int i = 0; i < 10; i++) begin
            ld = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 2));
            if (sz == 2'd0)      a = 2'($urandom_range(0, 3));
            else if (sz == 2'd1) a = {1'($urandom_range(0, 1)), 1'b0};
            else                 a = 2'b00;
            f3 = {ld && ($urandom_range(0, 1) == 1) && sz != 2'd2, 1'b0, 1'b0} | {1'b0, sz};
            addr = {20'h0, 8'($urandom), 2'b00, a};
            wd = $urandom;
            rw = $urandom;
            run_access("rnd", !ld, ld, f3, addr, wd, rw,
                       $urandom_range(0, 2), $urandom_range(0, 2),
                       {addr[31:2], 2'b00}, !ld, ld ? 4'b0000 : m_strb(sz, a),
                       m_wdata(sz, wd), m_load(f3, a, rw));
        end

        // Reset while waiting for read data abandons the access.
        @(posedge clk); #1;
        MemReadM = 1; funct3M = 3'b000; ALUResultM = 32'h101;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mem_valid) seen = 1;
        end
        check("rstw_valid_seen", 32'(seen), 1);
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        check("rstw_wait_stall", 32'(StallM), 1);
        #1;
        rst_n = 0; MemReadM = 0;
        #1;
        check("rstw_valid", 32'(mem_valid), 0);
        check("rstw_addr", mem_addr, 0);
        check("rstw_rdata", ReadDataM, 0);
        check("rstw_stall", 32'(StallM), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_rvalid = 0;
        repeat (2) begin
            @(negedge clk);
            check("rstw_post_rdata", ReadDataM, 0);
            check("rstw_post_valid", 32'(mem_valid), 0);
            check("rstw_post_stall", 32'(StallM), 0);
        end

`ifdef MISALIGN_TRAP_EN
        @(posedge clk); #1;
        MemReadM = 1; funct3M = 3'b010; ALUResultM = 32'h102;
        @(negedge clk);
        check("mis_idle_stall", 32'(StallM), 1);
        check("mis_idle_valid", 32'(mem_valid), 0);
        @(negedge clk);
        check("mis_pulse", 32'(MisalignM), 1);
        check("mis_done_stall", 32'(StallM), 0);
        check("mis_done_valid", 32'(mem_valid), 0);
        check("mis_rdata", ReadDataM, 0);
        @(posedge clk); #1;
        MemReadM = 0;
        @(negedge clk);
        check("mis_pulse_end", 32'(MisalignM), 0);
        check("mis_end_valid", 32'(mem_valid), 0);
`else
        run_access("lw_mis_ign", 0, 1, 3'b010, 32'h102, 0, 32'h11223344, 0, 0,
                   32'h100, 0, 4'b0000, 0, 32'h11223344);
        run_access("lh_mis_ign", 0, 1, 3'b001, 32'h101, 0, 32'hABCD8765, 1, 1,
                   32'h100, 0, 4'b0000, 0, 32'hFFFF8765);
        check("mis_tied", 32'(MisalignM), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit; consumes the EX/MEM register outputs (address, store data, control) and acts as the initiator toward data memory.
- Issues one request per load/store over a valid/ready request channel and an rvalid response channel.
- Handles byte/half/word strobes and load extraction with sign/zero extension.
- Holds the pipeline via StallM until the access completes.

Parameters:
DATA_WIDTH, 32, data and address width (only 32 supported)
TIMEOUT_W, 0, reserved; must be 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
MemWriteM  in  1  store in MEM stage
MemReadM  in  1  load in MEM stage
funct3M  in  3  size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
ALUResultM  in  DATA_WIDTH  byte address
WriteDataM  in  DATA_WIDTH  store data, unshifted
StallM  out  1  hold IF/ID/EX/EM registers
ReadDataM  out  DATA_WIDTH  extended load result, valid in DONE
mem_valid  out  1  request valid
mem_ready  in  1  request accepted
mem_we  out  1  1 = write
mem_addr  out  DATA_WIDTH  word-aligned address (addr[1:0] = 00)
mem_wdata  out  DATA_WIDTH  lane-shifted store data
mem_wstrb  out  4  byte enables (writes); 0000 on reads
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_WIDTH  read word
MisalignM  out  1  misaligned-access pulse (MISALIGN_TRAP_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_valid, mem_we, mem_wstrb, mem_addr, mem_wdata, ReadDataM, MisalignM all 0. Reset mid-access abandons it; any later mem_ready/mem_rvalid is ignored.
- req = MemWriteM | MemReadM. If both are high, treat as a load.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE -> REQ when req:
  - register mem_addr = {ALUResultM[31:2],2'b00}, mem_we, mem_wdata, mem_wstrb; set mem_valid=1.
  - Strobes: byte 0001<<a[1:0]; half 0011<<{a[1],0}; word 1111.
  - wdata = WriteDataM shifted left by 8*offset (byte/half lanes replicated is acceptable; strobes are authoritative).
- REQ: hold all request outputs stable until mem_ready=1. On acceptance mem_valid<=0, then store -> DONE, load -> WAIT. mem_rvalid is ignored in REQ.
- WAIT: on mem_rvalid, ReadDataM <= extend(mem_rdata >> 8*offset) per funct3 (LB/LH sign-extend, LBU/LHU zero-extend, LW as-is); -> DONE.
- DONE: one cycle; ReadDataM held; -> IDLE. ReadDataM otherwise holds its last value.
- StallM (combinational) = req & (state != DONE). It deasserts only in DONE, so the pipeline advances exactly once per access and IDLE never re-issues the same instruction.
- Latency: store ≥ 3 cycles (IDLE, REQ w/ ready, DONE); load ≥ 4 cycles. Each cycle of ready/rvalid delay adds one stall cycle.
- No req in IDLE: StallM=0, no request issued.
- funct3/offset are captured at IDLE for use in WAIT; input changes during stall are irrelevant.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: in IDLE, a half access with a[0]=1 or a word access with a[1:0]≠00 issues no request. MisalignM=1 for one cycle, FSM goes straight to DONE, ReadDataM=0.
- Undefined: misalignment is ignored (half uses a[1], word uses offset 0), MisalignM tied 0.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ready immediate -> mem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF; StallM high 2 cycles, low in DONE.
- SB addr 0x203, data 0x000000AB -> mem_addr 0x200, wstrb 1000, wdata[31:24]=0xAB.
- LB addr 0x101, rdata 0x0000_80_00 (byte1=0x80), rvalid 3 cycles after ready -> ReadDataM 0xFFFFFF80; LBU same -> 0x00000080; StallM spans all wait cycles.
- LH addr 0x102, rdata 0x7FFF1234 -> 0x00007FFF; ready withheld 4 cycles -> mem_valid/addr stable throughout.
- Reset asserted in WAIT, later rvalid pulse -> outputs zero, ReadDataM unchanged at 0, no DONE.
- With MISALIGN_TRAP_EN: LW addr 0x102 -> no mem_valid, MisalignM one-cycle pulse, StallM one cycle.
